// File: rtl/ram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ram_bus_arbiter : two-master arbiter and access sequencer for a word-wide
//                   single-port data RAM (partial stores done as RMW).
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_bus_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int RAM_NUM    = 4096,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic [3:0]        m0_be_i,
    output logic              m0_gnt_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic [3:0]        m1_be_i,
    output logic              m1_gnt_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              ram_wr_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              busy_o
);

    localparam int c_LANE_W = DATA_W / 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [3:0]        be_q, be_d;

    logic              sel;
    logic              req_we;
    logic              req_oor;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_be;

    // sel = 1 picks m1; on a tie round-robin hands the bus to whoever did not win last
    always_comb begin
        sel       = m1_req_i && (!m0_req_i || (FIXED_PRIO == 0 && !last_q));
        req_we    = sel ? m1_we_i    : m0_we_i;
        req_addr  = sel ? m1_addr_i  : m0_addr_i;
        req_wdata = sel ? m1_wdata_i : m0_wdata_i;
        req_be    = sel ? m1_be_i    : m0_be_i;
        req_oor   = (req_addr >> 2) >= ADDR_W'(RAM_NUM);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        be_d        = be_q;
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        m0_ack_o    = 1'b0;
        m1_ack_o    = 1'b0;
        m0_err_o    = 1'b0;
        m1_err_o    = 1'b0;
        m0_rdata_o  = '0;
        m1_rdata_o  = '0;
        ram_wr_en_o = 1'b0;
        ram_data_o  = '0;
        ram_addr_o  = addr_q;
        busy_o      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    owner_d  = sel;
                    last_d   = sel;
                    we_d     = req_we;
                    err_d    = req_oor;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    be_d     = req_be;
                    // grant is combinational, so keep it quiet while reset is held
                    m0_gnt_o = !sel && rst_n;
                    m1_gnt_o = sel && rst_n;
                    if (req_oor)               state_d = S_RESP;
                    else if (!req_we)          state_d = S_RD;
                    else if (req_be == 4'hF)   state_d = S_WR;
                    else if (req_be == 4'h0)   state_d = S_RESP;
                    else                       state_d = S_RMW_RD;
                end
            end
            S_RD: begin
                buf_d   = ram_data_i;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                for (int k = 0; k < 4; k++) begin
                    buf_d[k*c_LANE_W +: c_LANE_W] = be_q[k] ? wdata_q[k*c_LANE_W +: c_LANE_W]
                                                            : ram_data_i[k*c_LANE_W +: c_LANE_W];
                end
                state_d = S_WR;
            end
            S_WR: begin
                ram_wr_en_o = 1'b1;
                ram_data_o  = (be_q == 4'hF) ? wdata_q : buf_q;
                state_d     = S_RESP;
            end
            S_RESP: begin
                m0_ack_o   = !owner_q;
                m1_ack_o   = owner_q;
                m0_err_o   = !owner_q && err_q;
                m1_err_o   = owner_q && err_q;
                m0_rdata_o = (!owner_q && !we_q && !err_q) ? buf_q : '0;
                m1_rdata_o = (owner_q && !we_q && !err_q) ? buf_q : '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            be_q    <= be_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_bus_arbiter : directed vector bench, round-robin and fixed-priority
//                      instances side by side, each with its own RAM model.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_bus_arbiter;

    localparam int RAM_NUM = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_be = '0, m1_be = '0;

    logic        rr_m0_gnt, rr_m0_ack, rr_m0_err, rr_m1_gnt, rr_m1_ack, rr_m1_err;
    logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_addr, rr_wdat, rr_rdi;
    logic        rr_wr_en, rr_busy;
    logic        fp_m0_gnt, fp_m0_ack, fp_m0_err, fp_m1_gnt, fp_m1_ack, fp_m1_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_addr, fp_wdat, fp_rdi;
    logic        fp_wr_en, fp_busy;

    logic [31:0] rr_ram [0:RAM_NUM-1];
    logic [31:0] fp_ram [0:RAM_NUM-1];
    logic [29:0] rr_idx, fp_idx;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_bus_arbiter #(.DATA_W(32), .ADDR_W(32), .RAM_NUM(RAM_NUM), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_be_i(m0_be),
        .m0_gnt_o(rr_m0_gnt), .m0_ack_o(rr_m0_ack), .m0_err_o(rr_m0_err), .m0_rdata_o(rr_m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_be_i(m1_be),
        .m1_gnt_o(rr_m1_gnt), .m1_ack_o(rr_m1_ack), .m1_err_o(rr_m1_err), .m1_rdata_o(rr_m1_rdata),
        .ram_wr_en_o(rr_wr_en), .ram_addr_o(rr_addr), .ram_data_o(rr_wdat), .ram_data_i(rr_rdi),
        .busy_o(rr_busy)
    );

    ram_bus_arbiter #(.DATA_W(32), .ADDR_W(32), .RAM_NUM(RAM_NUM), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_be_i(m0_be),
        .m0_gnt_o(fp_m0_gnt), .m0_ack_o(fp_m0_ack), .m0_err_o(fp_m0_err), .m0_rdata_o(fp_m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_be_i(m1_be),
        .m1_gnt_o(fp_m1_gnt), .m1_ack_o(fp_m1_ack), .m1_err_o(fp_m1_err), .m1_rdata_o(fp_m1_rdata),
        .ram_wr_en_o(fp_wr_en), .ram_addr_o(fp_addr), .ram_data_o(fp_wdat), .ram_data_i(fp_rdi),
        .busy_o(fp_busy)
    );

    // RAM models: combinational read, clocked write
    assign rr_idx = rr_addr[31:2];
    assign fp_idx = fp_addr[31:2];
    assign rr_rdi = (rr_idx < 30'(RAM_NUM)) ? rr_ram[rr_idx[5:0]] : 32'h0;
    assign fp_rdi = (fp_idx < 30'(RAM_NUM)) ? fp_ram[fp_idx[5:0]] : 32'h0;

    always @(posedge clk) begin
        if (rr_wr_en && rr_idx < 30'(RAM_NUM)) rr_ram[rr_idx[5:0]] <= rr_wdat;
        if (fp_wr_en && fp_idx < 30'(RAM_NUM)) fp_ram[fp_idx[5:0]] <= fp_wdat;
    end

    typedef struct {
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wrs;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic rr_any_out();
        return |{rr_m0_gnt, rr_m0_ack, rr_m0_err, rr_m0_rdata, rr_m1_gnt, rr_m1_ack,
                 rr_m1_err, rr_m1_rdata, rr_wr_en, rr_addr, rr_wdat, rr_busy};
    endfunction

    task automatic do_reset();
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // one transaction on the round-robin instance; latency counted gnt -> ack
    task automatic run_txn(input logic m, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output int wrs, output logic other);
        int n;
        int g;
        n = 0; g = -1; lat = -1; wrs = 0; other = 1'b0; rdata = '0; err = 1'b0;
        @(negedge clk);
        if (!m) begin m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be; m0_req = 1'b1; end
        else    begin m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be; m1_req = 1'b1; end
        #1;
        while (n < 20) begin
            if (rr_wr_en) wrs++;
            if (m ? (rr_m0_gnt | rr_m0_ack | rr_m0_err) : (rr_m1_gnt | rr_m1_ack | rr_m1_err))
                other = 1'b1;
            if (g < 0 && (m ? rr_m1_gnt : rr_m0_gnt)) begin
                g = n;
            end else if (g >= 0 && (m ? rr_m1_ack : rr_m0_ack)) begin
                lat   = n - g;
                rdata = m ? rr_m1_rdata : rr_m0_rdata;
                err   = m ? rr_m1_err : rr_m0_err;
                break;
            end
            @(negedge clk);
            #1;
            n++;
            if (g >= 0) begin m0_req = 1'b0; m1_req = 1'b0; end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat, wrs;
        logic [31:0] rdata;
        logic        err, other;
        int          rr_g [4];
        int          rr_t [4];
        int          fp_g [4];
        int          nr, nf, cyc;

        //          m     we    addr      wdata         be     rdata         err   lat wrs
        vecs[0]  = '{1'b0, 1'b1, 32'h008, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0, 2, 1};
        vecs[1]  = '{1'b0, 1'b0, 32'h008, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0, 2, 0};
        vecs[2]  = '{1'b1, 1'b1, 32'h008, 32'h000000AA, 4'h1, 32'h00000000, 1'b0, 3, 1};
        vecs[3]  = '{1'b1, 1'b0, 32'h008, 32'h00000000, 4'h0, 32'hDEADBEAA, 1'b0, 2, 0};
        vecs[4]  = '{1'b0, 1'b0, 32'h100, 32'h00000000, 4'h0, 32'h00000000, 1'b1, 1, 0};
        vecs[5]  = '{1'b0, 1'b1, 32'h100, 32'h55555555, 4'hF, 32'h00000000, 1'b1, 1, 0};
        vecs[6]  = '{1'b1, 1'b1, 32'h008, 32'h12345678, 4'h0, 32'h00000000, 1'b0, 1, 0};
        vecs[7]  = '{1'b0, 1'b0, 32'h008, 32'h00000000, 4'h0, 32'hDEADBEAA, 1'b0, 2, 0};
        vecs[8]  = '{1'b0, 1'b1, 32'h00C, 32'h11223344, 4'hC, 32'h00000000, 1'b0, 3, 1};
        vecs[9]  = '{1'b1, 1'b0, 32'h00C, 32'h00000000, 4'h0, 32'h11220000, 1'b0, 2, 0};
        vecs[10] = '{1'b1, 1'b1, 32'h0FC, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b0, 2, 1};
        vecs[11] = '{1'b0, 1'b0, 32'h0FC, 32'h00000000, 4'h0, 32'hCAFEF00D, 1'b0, 2, 0};
        vecs[12] = '{1'b1, 1'b0, 32'h009, 32'h00000000, 4'h0, 32'hDEADBEAA, 1'b0, 2, 0};

        for (int i = 0; i < RAM_NUM; i++) begin
            rr_ram[i] = '0;
            fp_ram[i] = '0;
        end

        // reset state, observed while reset is held and after release
        #1;
        check("reset_outputs_held", {31'b0, rr_any_out()}, 32'h0);
        do_reset();
        check("reset_outputs_released", {31'b0, rr_any_out()}, 32'h0);

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                    lat, rdata, err, wrs, other);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            check($sformatf("v%0d_wr_cycles", i), 32'(wrs), 32'(vecs[i].exp_wrs));
            check($sformatf("v%0d_other_quiet", i), {31'b0, other}, 32'h0);
        end
        check("ram_word8", rr_ram[2], 32'hDEADBEAA);

        // both masters hold req: round-robin alternates, fixed priority starves m1
        do_reset();
        for (int i = 0; i < 4; i++) begin rr_g[i] = 9; rr_t[i] = -1; fp_g[i] = 9; end
        m0_we = 1'b0; m0_addr = 32'h008;
        m1_we = 1'b0; m1_addr = 32'h00C;
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        nr = 0; nf = 0; cyc = 0;
        while (cyc < 40 && (nr < 4 || nf < 4)) begin
            if (nr < 4 && (rr_m0_gnt || rr_m1_gnt)) begin
                rr_g[nr] = rr_m1_gnt ? 1 : 0;
                rr_t[nr] = cyc;
                nr++;
            end
            if (nf < 4 && (fp_m0_gnt || fp_m1_gnt)) begin
                fp_g[nf] = fp_m1_gnt ? 1 : 0;
                nf++;
            end
            @(negedge clk);
            #1;
            cyc++;
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_grant%0d", i), 32'(rr_g[i]), 32'(i % 2));
            check($sformatf("fp_grant%0d", i), 32'(fp_g[i]), 32'h0);
        end
        check("rr_regrant_spacing", 32'(rr_t[1] - rr_t[0]), 32'd3);

        // reset dropped into the WR cycle of a partial write
        do_reset();
        m0_we = 1'b1; m0_addr = 32'h010; m0_wdata = 32'hFFFFFFFF; m0_be = 4'h1;
        m0_req = 1'b1;
        #1;
        cyc = 0;
        while (cyc < 10 && !rr_m0_gnt) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("rst_wr_granted", {31'b0, rr_m0_gnt}, 32'h1);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rst_in_wr_cycle", {31'b0, rr_wr_en}, 32'h1);
        rst_n = 1'b0;
        m0_req = 1'b0;
        #1;
        check("rst_mid_outputs", {31'b0, rr_any_out()}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_no_ram_write", rr_ram[4], 32'h0);
        check("rst_no_ack", {30'b0, rr_m0_ack, rr_busy}, 32'h0);
        run_txn(1'b1, 1'b0, 32'h010, 32'h0, 4'h0, lat, rdata, err, wrs, other);
        check("post_rst_latency", 32'(lat), 32'd2);
        check("post_rst_rdata", rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
